// File: rtl/load_store_unit.sv
// Load/store unit: turns single core requests into one RAM access each, with
// alignment checking, byte-lane steering, load extension and a ready timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q;
    logic [1:0]         addr_lo_q;
    logic               we_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               mem_valid_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [3:0]         mem_we_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [31:0]        resp_rdata_q;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_en = 4'(4'b0001 << a);
            2'b01:   byte_en = 4'(4'b0011 << a);
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Lane-select the addressed bytes, then sign- or zero-extend.
    function automatic logic [31:0] load_data(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] a, input logic uns);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        case (size)
            2'b00:   load_data = uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   load_data = uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_data = s;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_lo_q    <= 2'b00;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            wait_cnt_q   <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_lo_q  <= req_addr_i[1:0];
                        we_q       <= req_we_i;
                        size_q     <= req_size_i;
                        unsigned_q <= req_unsigned_i;
                        if (misaligned(req_size_i, req_addr_i[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= ISSUE;
                            wait_cnt_q  <= '0;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                            mem_wdata_q <= store_data(req_size_i, req_wdata_i);
                            mem_we_q    <= req_we_i ? byte_en(req_size_i, req_addr_i[1:0])
                                                    : 4'b0000;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    mem_valid_q <= 1'b0;
                    mem_we_q    <= 4'b0000;
                    if (mem_ready_i) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0
                                             : load_data(mem_rdata_i, size_q, addr_lo_q, unsigned_q);
                    end else if (state_q == ISSUE) begin
                        state_q <= WAIT;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 ((wait_cnt_q + CNT_W'(1)) >= TIMEOUT_CYCLES)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is low for the whole reset window, high as soon as rst drops.
    assign req_ready_o  = (state_q == IDLE) && !rst;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: store/load flows, extension, errors,
// timeout and reset during an outstanding access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_rdata_i;

    int n_pass  = 0;
    int n_total = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_we_o       (mem_we_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_addr_i     = addr;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
    endtask

    // Full access with RAM ready one cycle after mem_valid_o.
    task automatic xact(input string tag, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] ram_word, input logic [3:0] exp_we,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
        drive_req(addr, we, size, uns, wdata);
        tick();
        req_valid_i = 1'b0;
        chk({tag, ".mvalid"}, 32'(mem_valid_o), 32'd1);
        chk({tag, ".maddr"}, mem_addr_o, {addr[31:2], 2'b00});
        chk({tag, ".mwe"}, 32'(mem_we_o), 32'(exp_we));
        if (we) chk({tag, ".mwdata"}, mem_wdata_o, exp_wdata);
        tick();
        chk({tag, ".mpulse"}, {31'd0, mem_valid_o} | {28'd0, mem_we_o} << 1, 32'd0);
        chk({tag, ".hold"}, mem_addr_o, {addr[31:2], 2'b00});
        mem_ready_i = 1'b1;
        mem_rdata_i = ram_word;
        tick();
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h5A5A_5A5A;
        chk({tag, ".rvalid"}, {30'd0, resp_valid_o, resp_err_o}, 32'd2);
        chk({tag, ".rdata"}, resp_rdata_o, exp_rdata);
        tick();
        chk({tag, ".rdone"}, {31'd0, resp_valid_o} | resp_rdata_o, 32'd0);
    endtask

    task automatic err_req(input string tag, input logic [31:0] addr, input logic [1:0] size);
        drive_req(addr, 1'b0, size, 1'b0, 32'hFFFF_FFFF);
        tick();
        req_valid_i = 1'b0;
        chk({tag, ".resp"}, {resp_rdata_o[29:0], resp_valid_o, resp_err_o}, 32'd3);
        chk({tag, ".rdata"}, resp_rdata_o, 32'd0);
        chk({tag, ".nomem"}, 32'(mem_valid_o), 32'd0);
        tick();
        chk({tag, ".done"}, {30'd0, resp_valid_o, resp_err_o}, 32'd0);
    endtask

    initial begin
        logic early;
        rst            = 1'b1;
        req_valid_i    = 1'b0;
        req_addr_i     = '0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_wdata_i    = '0;
        mem_ready_i    = 1'b0;
        mem_rdata_i    = '0;
        tick();
        tick();
        chk("rst.ready", 32'(req_ready_o), 32'd0);
        chk("rst.mem", {27'd0, mem_valid_o, mem_we_o} | mem_addr_o | mem_wdata_o, 32'd0);
        chk("rst.resp", {30'd0, resp_valid_o, resp_err_o} | resp_rdata_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel.ready", 32'(req_ready_o), 32'd1);

        // mem_ready_i while idle must not produce a response
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        tick();
        chk("idle.ignore", {30'd0, resp_valid_o, req_ready_o}, 32'd1);

        xact("sw",   32'h100, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,
             4'b1111, 32'hDEAD_BEEF, 32'h0);
        xact("lw",   32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF,
             4'b0000, 32'h0, 32'hDEAD_BEEF);
        xact("lb",   32'h103, 1'b0, 2'b00, 1'b0, 32'h0, 32'h80FF_0000,
             4'b0000, 32'h0, 32'hFFFF_FF80);
        xact("lbu",  32'h103, 1'b0, 2'b00, 1'b1, 32'h0, 32'h80FF_0000,
             4'b0000, 32'h0, 32'h0000_0080);
        xact("sh",   32'h102, 1'b1, 2'b01, 1'b0, 32'hFFFF_1234, 32'h0,
             4'b1100, 32'h1234_1234, 32'h0);
        xact("lh",   32'h102, 1'b0, 2'b01, 1'b0, 32'h0, 32'h8001_5555,
             4'b0000, 32'h0, 32'hFFFF_8001);
        xact("lhu",  32'h100, 1'b0, 2'b01, 1'b1, 32'h0, 32'h8001_F00D,
             4'b0000, 32'h0, 32'h0000_F00D);
        xact("sb",   32'h101, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, 32'h0,
             4'b0010, 32'hABAB_ABAB, 32'h0);
        xact("lb1",  32'h101, 1'b0, 2'b00, 1'b0, 32'h0, 32'h1122_7F44,
             4'b0000, 32'h0, 32'h0000_007F);

        err_req("mis_w", 32'h101, 2'b10);
        err_req("size3", 32'h100, 2'b11);
        err_req("mis_h", 32'h103, 2'b01);

        // Timeout: 16 WAIT cycles with no ready, response on the next
        drive_req(32'h200, 1'b0, 2'b10, 1'b0, 32'h0);
        tick();
        req_valid_i = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (resp_valid_o !== 1'b0) early = 1'b1;
        end
        chk("to.early", 32'(early), 32'd0);
        chk("to.hold", mem_addr_o, 32'h200);
        tick();
        chk("to.resp", {30'd0, resp_valid_o, resp_err_o}, 32'd3);
        chk("to.rdata", resp_rdata_o, 32'd0);
        tick();
        chk("to.done", {30'd0, resp_valid_o, req_ready_o}, 32'd1);

        // Reset while waiting; pending access must never complete
        drive_req(32'h300, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D);
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mem_ready_i = 1'b1;
        #1;
        chk("mrst.mem", {27'd0, mem_valid_o, mem_we_o} | mem_addr_o | mem_wdata_o, 32'd0);
        chk("mrst.resp", {29'd0, resp_valid_o, resp_err_o, req_ready_o} | resp_rdata_o, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mrst.ready", 32'(req_ready_o), 32'd1);
        tick();
        mem_ready_i = 1'b0;
        tick();
        chk("mrst.nocomplete", {30'd0, resp_valid_o, mem_valid_o}, 32'd0);
        xact("post", 32'h104, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_3344,
             4'b0000, 32'h0, 32'h1122_3344);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
